memory_interface_unit: RTL and testbench

MEMORY_INTERFACE_UNIT -- requirements
Module: memory_interface_unit

---
 rtl/cpu_mem_pkg.sv | 28 ++
 rtl/memory_interface_unit_if.sv | 31 +++
 rtl/memory_interface_unit.sv | 155 +++++++++++++++
 tb/tb_memory_interface_unit.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU-to-byte-bus memory interface.
// Holds the FSM encoding, beat counts and the big-endian lane mapping.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEAT = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    localparam int unsigned BEATS_WORD = 4;
    localparam int unsigned BEATS_BYTE = 1;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned BYTE_W     = 8;

    // Beat 0 carries the most significant byte of a word.
    function automatic logic [4:0] lane_lsb(input logic [1:0] beat);
        return {2'(2'd3 - beat), 3'b000};
    endfunction

    function automatic logic [7:0] lane_byte(input logic [31:0] word,
                                             input logic        is_word,
                                             input logic [1:0]  beat);
        return is_word ? word[lane_lsb(beat) +: 8] : word[7:0];
    endfunction

endpackage

// File: rtl/memory_interface_unit_if.sv
// Bundle of the control-unit request signals and the 8-bit memory bus.
// master = request/bus-responder side, slave = the memory interface unit.
interface memory_interface_unit_if;
    import cpu_mem_pkg::*;

    logic                MFA;
    logic                READ_WRITE;
    logic                WORD_BYTE;
    logic [ADDR_W-1:0]   Address;
    logic [DATA_W-1:0]   DataIn;
    logic [DATA_W-1:0]   DataOut;
    logic                MFC;
    logic                AlignErr;
    logic [ADDR_W-1:0]   BusAddr;
    logic [BYTE_W-1:0]   BusWData;
    logic [BYTE_W-1:0]   BusRData;
    logic                BusReq;
    logic                BusWE;
    logic                BusAck;

    modport master (
        output MFA, READ_WRITE, WORD_BYTE, Address, DataIn, BusRData, BusAck,
        input  DataOut, MFC, AlignErr, BusAddr, BusWData, BusReq, BusWE
    );

    modport slave (
        input  MFA, READ_WRITE, WORD_BYTE, Address, DataIn, BusRData, BusAck,
        output DataOut, MFC, AlignErr, BusAddr, BusWData, BusReq, BusWE
    );

endinterface

// File: rtl/memory_interface_unit.sv
// Serialises 32-bit word / byte CPU accesses onto an 8-bit acked memory bus.
// Big-endian beat order; all outputs registered.
module memory_interface_unit
    import cpu_mem_pkg::*;
(
    input  logic                Clk,
    input  logic                Reset,
    input  logic                MFA,
    input  logic                READ_WRITE,
    input  logic                WORD_BYTE,
    input  logic [ADDR_W-1:0]   Address,
    input  logic [DATA_W-1:0]   DataIn,
    output logic [DATA_W-1:0]   DataOut,
    output logic                MFC,
    output logic                AlignErr,
    output logic [ADDR_W-1:0]   BusAddr,
    output logic [BYTE_W-1:0]   BusWData,
    input  logic [BYTE_W-1:0]   BusRData,
    output logic                BusReq,
    output logic                BusWE,
    input  logic                BusAck
);

    mem_state_e          state_q, state_d;
    logic [1:0]          beat_q, beat_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                rd_q, rd_d;
    logic                word_q, word_d;
    logic [23:0]         asm_q, asm_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [BYTE_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic                mfc_q, mfc_d;
    logic                align_q, align_d;
    logic                req_q, req_d;
    logic                we_q, we_d;

    logic [1:0]          last_beat;
    logic [1:0]          next_beat;
    logic [ADDR_W-1:0]   req_base;

    assign last_beat = word_q ? 2'(BEATS_WORD - 1) : 2'(BEATS_BYTE - 1);
    assign next_beat = beat_q + 2'd1;
    // Word accesses are forced onto a word boundary.
    assign req_base  = WORD_BYTE ? {Address[ADDR_W-1:2], 2'b00} : Address;

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        rd_d        = rd_q;
        word_d      = word_q;
        asm_d       = asm_q;
        dout_d      = dout_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        mfc_d       = mfc_q;
        align_d     = 1'b0;
        req_d       = req_q;
        we_d        = we_q;

        unique case (state_q)
            IDLE: begin
                if (MFA) begin
                    state_d     = BEAT;
                    base_d      = req_base;
                    wdata_d     = DataIn;
                    rd_d        = READ_WRITE;
                    word_d      = WORD_BYTE;
                    beat_d      = 2'd0;
                    align_d     = WORD_BYTE && (Address[1:0] != 2'b00);
                    req_d       = 1'b1;
                    we_d        = !READ_WRITE;
                    bus_addr_d  = req_base;
                    bus_wdata_d = lane_byte(DataIn, WORD_BYTE, 2'd0);
                end
            end
            BEAT: begin
                if (BusAck) begin
                    if (rd_q) begin
                        asm_d = {asm_q[15:0], BusRData};
                    end
                    if (beat_q == last_beat) begin
                        state_d = DONE;
                        req_d   = 1'b0;
                        we_d    = 1'b0;
                        mfc_d   = 1'b1;
                        if (rd_q) begin
                            dout_d = word_q ? {asm_q, BusRData} : {24'h0, BusRData};
                        end
                    end else begin
                        beat_d      = next_beat;
                        bus_addr_d  = base_q + ADDR_W'(next_beat);
                        bus_wdata_d = lane_byte(wdata_q, word_q, next_beat);
                    end
                end
            end
            DONE: begin
                if (!MFA) begin
                    state_d = IDLE;
                    mfc_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            beat_q      <= 2'd0;
            base_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= 1'b0;
            word_q      <= 1'b0;
            asm_q       <= '0;
            dout_q      <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            mfc_q       <= 1'b0;
            align_q     <= 1'b0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            word_q      <= word_d;
            asm_q       <= asm_d;
            dout_q      <= dout_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            mfc_q       <= mfc_d;
            align_q     <= align_d;
            req_q       <= req_d;
            we_q        <= we_d;
        end
    end

    assign DataOut  = dout_q;
    assign MFC      = mfc_q;
    assign AlignErr = align_q;
    assign BusAddr  = bus_addr_q;
    assign BusWData = bus_wdata_q;
    assign BusReq   = req_q;
    assign BusWE    = we_q;

endmodule

// File: tb/tb_memory_interface_unit.sv
// Scoreboard bench for memory_interface_unit: driver pushes expected beats and
// completions, a negedge monitor compares, a bus responder supplies acks/data.
module tb_memory_interface_unit;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [7:0]  wdata;
    } beat_t;

    typedef struct {
        int          sample;
        int          mfc_edge;
        bit          align;
        logic [31:0] dout;
    } item_t;

    logic Clk = 1'b0;
    logic Reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;
    logic mfc_prev = 1'b0;

    beat_t       beat_q[$];
    item_t       item_q[$];
    int          fall_q[$];
    int          stall_q[$];
    logic [7:0]  rb_q[$];

    logic [31:0] model_dout = 32'h0;
    logic [7:0]  rb_a [4];
    int          st_a [4];

    memory_interface_unit_if mif();

    memory_interface_unit dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .MFA        (mif.MFA),
        .READ_WRITE (mif.READ_WRITE),
        .WORD_BYTE  (mif.WORD_BYTE),
        .Address    (mif.Address),
        .DataIn     (mif.DataIn),
        .DataOut    (mif.DataOut),
        .MFC        (mif.MFC),
        .AlignErr   (mif.AlignErr),
        .BusAddr    (mif.BusAddr),
        .BusWData   (mif.BusWData),
        .BusRData   (mif.BusRData),
        .BusReq     (mif.BusReq),
        .BusWE      (mif.BusWE),
        .BusAck     (mif.BusAck)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out at cyc %0d", name, cyc);
    endtask

    // Bus responder: per beat, hold ack low for the queued stall count, then ack with the queued byte.
    initial begin : responder
        bit         started;
        int         stall_left;
        logic [7:0] rbyte;
        logic       req_s, ack_s;
        started = 1'b0;
        stall_left = 0;
        rbyte = 8'h00;
        mif.BusAck = 1'b0;
        mif.BusRData = 8'h00;
        forever begin
            @(negedge Clk);
            req_s = mif.BusReq;
            ack_s = mif.BusAck;
            @(posedge Clk);
            #1;
            if ((req_s && ack_s) || !mif.BusReq) started = 1'b0;
            if (mif.BusReq) begin
                if (!started) begin
                    started = 1'b1;
                    stall_left = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
                    rbyte = (rb_q.size() > 0) ? rb_q.pop_front() : 8'h00;
                end
                if (stall_left > 0) begin
                    mif.BusAck = 1'b0;
                    stall_left--;
                end else begin
                    mif.BusAck = 1'b1;
                    mif.BusRData = rbyte;
                end
            end else begin
                mif.BusAck = 1'b0;
            end
        end
    end

    // Monitor: bus beats, AlignErr pulse, MFC rise (latency + DataOut) and MFC fall.
    initial begin : monitor
        item_t it;
        bit    exp_al;
        int    fe;
        forever begin
            @(negedge Clk);
            if (mon_en) begin
                if (mif.BusReq) begin
                    if (beat_q.size() == 0) begin
                        chk("unexpected_beat", 32'(mif.BusReq), 32'h0);
                    end else begin
                        chk("bus_addr", mif.BusAddr, beat_q[0].addr);
                        chk("bus_we", 32'(mif.BusWE), 32'(beat_q[0].we));
                        if (beat_q[0].we) chk("bus_wdata", 32'(mif.BusWData), 32'(beat_q[0].wdata));
                        if (mif.BusAck) void'(beat_q.pop_front());
                    end
                end
                exp_al = (item_q.size() > 0) && item_q[0].align && (cyc == item_q[0].sample);
                chk("align_err", 32'(mif.AlignErr), 32'(exp_al));
                if (mif.MFC === 1'b1 && mfc_prev === 1'b0) begin
                    if (item_q.size() == 0) begin
                        chk("unexpected_mfc", 32'(mif.MFC), 32'h0);
                    end else begin
                        it = item_q.pop_front();
                        // Latency counts the MFA sample edge as cycle 1.
                        chk("mfc_latency", 32'(cyc - it.sample + 1), 32'(it.mfc_edge - it.sample + 1));
                        chk("data_out", mif.DataOut, it.dout);
                        chk("beats_left_at_mfc", 32'(beat_q.size()), 32'h0);
                    end
                end
                if (mif.MFC === 1'b0 && mfc_prev === 1'b1) begin
                    if (fall_q.size() == 0) begin
                        chk("unexpected_mfc_fall", 32'(mif.MFC), 32'h1);
                    end else begin
                        fe = fall_q.pop_front();
                        chk("mfc_fall_edge", 32'(cyc), 32'(fe));
                    end
                end
                mfc_prev = mif.MFC;
            end
        end
    end

    // One access: hold < 0 drops MFA right after the sample edge, else MFA is held hold cycles past MFC.
    task automatic issue(input bit rw, input bit wb, input logic [31:0] addr,
                         input logic [31:0] din, input int hold);
        int          nb;
        int          lat;
        int          n;
        logic [31:0] base;
        logic [31:0] acc;
        item_t       it;
        beat_t       b;
        nb   = wb ? 4 : 1;
        base = wb ? {addr[31:2], 2'b00} : addr;
        lat  = 0;
        acc  = 32'h0;
        for (int i = 0; i < nb; i++) begin
            b.addr  = base + 32'(i);
            b.we    = !rw;
            b.wdata = wb ? din[8*(3-i) +: 8] : din[7:0];
            beat_q.push_back(b);
            stall_q.push_back(st_a[i]);
            rb_q.push_back(rb_a[i]);
            lat += 1 + st_a[i];
            acc = {acc[23:0], rb_a[i]};
        end
        if (rw) model_dout = wb ? acc : {24'h0, rb_a[0]};
        @(posedge Clk);
        #1;
        it.sample   = cyc + 1;
        it.mfc_edge = cyc + 1 + lat;
        it.align    = wb && (addr[1:0] != 2'b00);
        it.dout     = model_dout;
        item_q.push_back(it);
        mif.MFA = 1'b1;
        mif.READ_WRITE = rw;
        mif.WORD_BYTE = wb;
        mif.Address = addr;
        mif.DataIn = din;
        if (hold < 0) begin
            @(posedge Clk);
            #1;
            mif.MFA = 1'b0;
            mif.Address = $urandom;
            mif.DataIn = $urandom;
            fall_q.push_back(it.mfc_edge + 1);
            n = 0;
            do begin
                @(negedge Clk);
                n++;
            end while ((mif.MFC === 1'b1 || cyc <= it.mfc_edge) && n < 500);
            if (n >= 500) timeout("drop_wait");
        end else begin
            n = 0;
            do begin
                @(negedge Clk);
                n++;
            end while (mif.MFC !== 1'b1 && n < 500);
            if (n >= 500) timeout("mfc_wait");
            repeat (hold) @(negedge Clk);
            @(posedge Clk);
            #1;
            fall_q.push_back(cyc + 1);
            mif.MFA = 1'b0;
            n = 0;
            do begin
                @(negedge Clk);
                n++;
            end while (mif.MFC === 1'b1 && n < 500);
            if (n >= 500) timeout("fall_wait");
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        Reset = 1'b0;
        mif.MFA = 1'b0;
        mif.READ_WRITE = 1'b0;
        mif.WORD_BYTE = 1'b0;
        mif.Address = 32'h0;
        mif.DataIn = 32'h0;
        #12;
        chk("rst_data_out", mif.DataOut, 32'h0);
        chk("rst_mfc", 32'(mif.MFC), 32'h0);
        chk("rst_bus_req", 32'(mif.BusReq), 32'h0);
        chk("rst_bus_we", 32'(mif.BusWE), 32'h0);
        chk("rst_align", 32'(mif.AlignErr), 32'h0);
        chk("rst_bus_addr", mif.BusAddr, 32'h0);
        chk("rst_bus_wdata", 32'(mif.BusWData), 32'h0);
        #5;
        Reset = 1'b1;
        mon_en = 1'b1;

        st_a = '{0, 0, 0, 0};
        rb_a = '{8'h11, 8'h22, 8'h33, 8'h44};
        issue(1'b1, 1'b1, 32'h10, 32'h0, 0);
        issue(1'b0, 1'b0, 32'h25, 32'hAABBCCDD, 0);
        st_a = '{0, 3, 0, 0};
        issue(1'b0, 1'b1, 32'h40, 32'h01020304, 1);
        st_a = '{0, 0, 0, 0};
        rb_a = '{8'hC0, 8'hFF, 8'hEE, 8'h0D};
        issue(1'b1, 1'b1, 32'h0E, 32'h0, 0);
        rb_a = '{8'h7E, 8'h00, 8'h00, 8'h00};
        issue(1'b1, 1'b0, 32'h31, 32'h0, 4);
        st_a = '{1, 0, 2, 0};
        issue(1'b0, 1'b1, 32'h50, 32'hCAFEF00D, -1);
        st_a = '{0, 0, 0, 0};
        rb_a = '{8'hA5, 8'h00, 8'h00, 8'h00};
        issue(1'b1, 1'b0, 32'h63, 32'h0, -1);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 4; i++) begin
                st_a[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                rb_a[i] = 8'($urandom);
            end
            issue(1'($urandom), 1'($urandom), $urandom, $urandom,
                  int'($urandom_range(0, 4)) - 1);
            repeat ($urandom_range(0, 2)) @(posedge Clk);
        end

        // Reset in the middle of beat 2 of a word read, then a clean byte read.
        mon_en = 1'b0;
        st_a = '{0, 0, 0, 0};
        for (int i = 0; i < 4; i++) begin
            stall_q.push_back(0);
            rb_q.push_back(8'h90 + 8'(i));
        end
        @(posedge Clk);
        #1;
        mif.MFA = 1'b1;
        mif.READ_WRITE = 1'b1;
        mif.WORD_BYTE = 1'b1;
        mif.Address = 32'h80;
        repeat (3) @(posedge Clk);
        #3;
        chk("pre_rst_bus_req", 32'(mif.BusReq), 32'h1);
        chk("pre_rst_bus_addr", mif.BusAddr, 32'h82);
        Reset = 1'b0;
        #1;
        chk("mid_rst_bus_req", 32'(mif.BusReq), 32'h0);
        chk("mid_rst_mfc", 32'(mif.MFC), 32'h0);
        chk("mid_rst_data_out", mif.DataOut, 32'h0);
        chk("mid_rst_bus_addr", mif.BusAddr, 32'h0);
        chk("mid_rst_bus_we", 32'(mif.BusWE), 32'h0);
        mif.MFA = 1'b0;
        beat_q.delete();
        item_q.delete();
        fall_q.delete();
        stall_q.delete();
        rb_q.delete();
        model_dout = 32'h0;
        #4;
        Reset = 1'b1;
        mfc_prev = 1'b0;
        mon_en = 1'b1;
        rb_a = '{8'h3C, 8'h00, 8'h00, 8'h00};
        issue(1'b1, 1'b0, 32'h91, 32'h0, 0);
        repeat (3) @(negedge Clk);
        chk("end_bus_req", 32'(mif.BusReq), 32'h0);
        chk("end_items_left", 32'(item_q.size() + beat_q.size() + fall_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
